imm_encoder: RTL

Pipelined immediate encoder: the inverse of the core's immediate extender. It takes a 32-bit signed immediate value, a format code and a base instruction word. It range-checks the immediate, then scatters it into the format's immediate bit positions to produce a complete RV32I instruction word. It sits between the assembler/test-program generator path and instruction memory load logic, with valid/ready on both sides. For every legal input, passing the output through the core's immediate extender returns the original immediate.

---
 rtl/imm_encoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// Pipelined RV32I immediate encoder: range-checks an immediate and scatters it
// into the immediate fields of a base instruction word, with valid/ready on both sides.
module imm_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op_type,
    input  logic [31:0]      imm,
    input  logic [31:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned W = 32;

    localparam logic [2:0] OP_I = 3'd0;
    localparam logic [2:0] OP_S = 3'd2;
    localparam logic [2:0] OP_B = 3'd3;
    localparam logic [2:0] OP_U = 3'd4;
    localparam logic [2:0] OP_J = 3'd5;
    localparam logic [2:0] OP_R = 3'd6;

    logic           s1_valid;
    logic [2:0]     s1_op;
    logic [W-1:0]   s1_base;
    logic           s1_ok;
    logic [W-1:0]   s1_sh;

    logic           s2_valid;
    logic [W-1:0]   s2_inst;
    logic           s2_err;

    logic           s1_load;
    logic           s2_load;
    logic           legal_c;
    logic [W-1:0]   shuffled_c;
    logic [W-1:0]   mask_c;
    logic [W-1:0]   merged_c;
    logic signed [W-1:0] imm_s;

    // A stage loads when empty or when its content moves on this cycle.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    assign out_valid = s2_valid;
    assign out_inst  = s2_inst;
    assign out_err   = s2_err;

    assign imm_s = $signed(imm);

    // Range check and pre-shuffle of the immediate into instruction bit positions.
    always_comb begin
        legal_c    = 1'b0;
        shuffled_c = '0;
        case (op_type)
            OP_I: begin
                legal_c    = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
                shuffled_c = {imm[11:0], 20'b0};
            end
            OP_S: begin
                legal_c    = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
                shuffled_c = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            end
            OP_B: begin
                legal_c    = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
                shuffled_c = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            end
            OP_U: begin
                legal_c    = (imm[11:0] == 12'b0);
                shuffled_c = {imm[31:12], 12'b0};
            end
            OP_J: begin
                legal_c    = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
                shuffled_c = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            end
            OP_R: begin
                legal_c    = 1'b1;
                shuffled_c = '0;
            end
            default: begin
                legal_c    = 1'b0;
                shuffled_c = '0;
            end
        endcase
    end

    // Immediate field mask for the format held in stage 1.
    always_comb begin
        mask_c = '0;
        case (s1_op)
            OP_I:       mask_c = 32'hFFF0_0000;
            OP_S, OP_B: mask_c = 32'hFE00_0F80;
            OP_U, OP_J: mask_c = 32'hFFFF_F000;
            default:    mask_c = '0;
        endcase
        merged_c = (s1_base & ~mask_c) | (s1_ok ? (s1_sh & mask_c) : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_base  <= '0;
            s1_ok    <= 1'b0;
            s1_sh    <= '0;
        end else begin
            if (flush)        s1_valid <= 1'b0;
            else if (s1_load) s1_valid <= in_valid;
            if (s1_load && in_valid) begin
                s1_op   <= op_type;
                s1_base <= base;
                s1_ok   <= legal_c;
                s1_sh   <= shuffled_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_inst  <= '0;
            s2_err   <= 1'b0;
        end else begin
            if (flush)        s2_valid <= 1'b0;
            else if (s2_load) s2_valid <= s1_valid;
            if (s2_load && s1_valid) begin
                s2_inst <= merged_c;
                s2_err  <= !s1_ok;
            end
        end
    end

    // Saturating count of delivered error words; a word leaving during flush still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (s2_valid && out_ready && s2_err && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule
